// File: rtl/multi_zone_irrigation_scheduler.sv
// Round-robin irrigation scheduler: serves one zone at a time from a shared tank,
// with per-mode countdowns, a cooldown gap, supply-valve hysteresis and fault latching.
module multi_zone_irrigation_scheduler #(
  parameter int N_ZONES        = 4,
  parameter int SPRINKLER_SECS = 30,
  parameter int DRIPPER_SECS   = 90,
  parameter int GAP_SECS       = 5,
  parameter int TIMER_WIDTH    = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         tick_1hz,
  input  logic                         low_water_level,
  input  logic                         mid_water_level,
  input  logic                         high_water_level,
  input  logic                         air_humidity,
  input  logic                         low_temperature,
  input  logic [N_ZONES-1:0]           earth_humidity,
  input  logic [N_ZONES-1:0]           zone_enable,
  output logic [N_ZONES-1:0]           sprinkler_bomb,
  output logic [N_ZONES-1:0]           dripper_valvule,
  output logic [$clog2(N_ZONES)-1:0]   active_zone,
  output logic [TIMER_WIDTH-1:0]       remaining_seconds,
  output logic                         water_supply_valvule,
  output logic                         alarm,
  output logic                         error
);

  localparam int ZW = $clog2(N_ZONES);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_IRRIGATE, S_COOLDOWN, S_FAULT} state_t;

  state_t                 state_reg, state_next;
  logic [TIMER_WIDTH-1:0] timer_reg, timer_next;
  logic [ZW-1:0]          zone_reg, zone_next;
  logic [ZW-1:0]          ptr_reg, ptr_next;
  logic [ZW-1:0]          scan_idx_reg, scan_idx_next;
  logic [ZW:0]            scan_cnt_reg, scan_cnt_next;
  logic                   mode_reg, mode_next;   // 1 = sprinkler, 0 = dripper
  logic                   supply_next;
  logic                   conflict, abort_run;
  logic [N_ZONES-1:0]     eligible, zone_onehot;

  assign conflict = (mid_water_level & ~low_water_level) | (high_water_level & ~mid_water_level);

  for (genvar gi = 0; gi < N_ZONES; gi++) begin : g_zone
    assign eligible[gi]    = zone_enable[gi] & ~earth_humidity[gi] & low_water_level;
    assign zone_onehot[gi] = (zone_next == ZW'(gi));
  end

  function automatic logic [ZW-1:0] next_zone(input logic [ZW-1:0] idx);
    return (idx == ZW'(N_ZONES - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign abort_run = earth_humidity[zone_reg] | ~zone_enable[zone_reg] | ~low_water_level;

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    zone_next     = zone_reg;
    ptr_next      = ptr_reg;
    scan_idx_next = scan_idx_reg;
    scan_cnt_next = scan_cnt_reg;
    mode_next     = mode_reg;
    if (conflict) begin
      state_next = S_FAULT;
      timer_next = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (low_water_level) begin
            state_next    = S_SCAN;
            scan_idx_next = next_zone(ptr_reg);
            scan_cnt_next = '0;
          end
        end
        S_SCAN: begin
          if (eligible[scan_idx_reg]) begin
            state_next = S_IRRIGATE;
            zone_next  = scan_idx_reg;
            ptr_next   = scan_idx_reg;
            mode_next  = ~air_humidity & ~low_temperature & mid_water_level;
            timer_next = mode_next ? TIMER_WIDTH'(SPRINKLER_SECS) : TIMER_WIDTH'(DRIPPER_SECS);
          end else if (scan_cnt_reg == (ZW+1)'(N_ZONES - 1)) begin
            state_next = S_IDLE;
          end else begin
            scan_idx_next = next_zone(scan_idx_reg);
            scan_cnt_next = scan_cnt_reg + 1'b1;
          end
        end
        S_IRRIGATE: begin
          // An abort coinciding with the final tick still yields a single move to cooldown.
          if (abort_run || (tick_1hz && timer_reg <= TIMER_WIDTH'(1))) begin
            state_next = S_COOLDOWN;
            timer_next = TIMER_WIDTH'(GAP_SECS);
          end else if (tick_1hz) begin
            timer_next = timer_reg - 1'b1;
          end
        end
        S_COOLDOWN: begin
          if (tick_1hz) begin
            if (timer_reg <= TIMER_WIDTH'(1)) begin
              state_next = S_IDLE;
              timer_next = '0;
            end else begin
              timer_next = timer_reg - 1'b1;
            end
          end
        end
        S_FAULT: begin
          timer_next = '0;
          if (tick_1hz) begin
            state_next = S_COOLDOWN;
            timer_next = TIMER_WIDTH'(GAP_SECS);
          end
        end
        default: begin
          state_next = S_IDLE;
          timer_next = '0;
        end
      endcase
    end
  end

  // Inlet hysteresis: open below mid, close at high, hold in between.
  always_comb begin
    supply_next = water_supply_valvule;
    if (high_water_level || conflict)
      supply_next = 1'b0;
    else if (!mid_water_level)
      supply_next = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg            <= S_IDLE;
      timer_reg            <= '0;
      zone_reg             <= '0;
      ptr_reg              <= ZW'(N_ZONES - 1);
      scan_idx_reg         <= '0;
      scan_cnt_reg         <= '0;
      mode_reg             <= 1'b0;
      sprinkler_bomb       <= '0;
      dripper_valvule      <= '0;
      water_supply_valvule <= 1'b0;
      alarm                <= 1'b0;
      error                <= 1'b0;
    end else begin
      state_reg            <= state_next;
      timer_reg            <= timer_next;
      zone_reg             <= zone_next;
      ptr_reg              <= ptr_next;
      scan_idx_reg         <= scan_idx_next;
      scan_cnt_reg         <= scan_cnt_next;
      mode_reg             <= mode_next;
      sprinkler_bomb       <= (state_next == S_IRRIGATE &&  mode_next) ? zone_onehot : '0;
      dripper_valvule      <= (state_next == S_IRRIGATE && !mode_next) ? zone_onehot : '0;
      water_supply_valvule <= supply_next;
      alarm                <= (state_next == S_FAULT) | ~mid_water_level;
      error                <= (state_next == S_FAULT);
    end
  end

  assign active_zone       = zone_reg;
  assign remaining_seconds = timer_reg;

endmodule

// File: tb/tb_multi_zone_irrigation_scheduler.sv
// Directed bench for the irrigation scheduler: level table plus multi-cycle run sequences.
module tb_multi_zone_irrigation_scheduler;

  localparam int SPR = 30;
  localparam int DRP = 90;
  localparam int GAP = 5;

  logic       clock = 1'b0;
  logic       reset, tick_1hz;
  logic       low_water_level, mid_water_level, high_water_level;
  logic       air_humidity, low_temperature;
  logic [3:0] earth_humidity, zone_enable;
  logic [3:0] sprinkler_bomb, dripper_valvule;
  logic [1:0] active_zone;
  logic [7:0] remaining_seconds;
  logic       water_supply_valvule, alarm, error;

  int n_checks = 0;
  int n_pass   = 0;

  multi_zone_irrigation_scheduler #(
    .N_ZONES(4), .SPRINKLER_SECS(SPR), .DRIPPER_SECS(DRP), .GAP_SECS(GAP), .TIMER_WIDTH(8)
  ) dut (
    .clock(clock), .reset(reset), .tick_1hz(tick_1hz),
    .low_water_level(low_water_level), .mid_water_level(mid_water_level),
    .high_water_level(high_water_level), .air_humidity(air_humidity),
    .low_temperature(low_temperature), .earth_humidity(earth_humidity),
    .zone_enable(zone_enable), .sprinkler_bomb(sprinkler_bomb),
    .dripper_valvule(dripper_valvule), .active_zone(active_zone),
    .remaining_seconds(remaining_seconds), .water_supply_valvule(water_supply_valvule),
    .alarm(alarm), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic l, m, h;
    logic valve, alarm, error;
  } vec_t;
  vec_t tbl [7];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) begin
      n_pass++;
      $display("ok   %s = %0d", name, actual);
    end else begin
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic wait_drive(input logic [3:0] exp_spr, input logic [3:0] exp_drp,
                            input int exp_zone, input int exp_secs);
    int n = 0;
    while ((sprinkler_bomb | dripper_valvule) == 4'b0 && n < 40) begin
      step();
      n++;
    end
    check("start_sprinkler", int'(sprinkler_bomb), int'(exp_spr));
    check("start_dripper", int'(dripper_valvule), int'(exp_drp));
    check("start_zone", int'(active_zone), exp_zone);
    check("start_secs", int'(remaining_seconds), exp_secs);
  endtask

  task automatic run_out(input int secs, input logic [3:0] exp_spr, input logic [3:0] exp_drp);
    for (int i = 1; i <= secs; i++) begin
      pulse_tick();
      if (i < secs) begin
        check("run_secs", int'(remaining_seconds), secs - i);
        if (i == secs - 1) begin
          check("run_last_sprinkler", int'(sprinkler_bomb), int'(exp_spr));
          check("run_last_dripper", int'(dripper_valvule), int'(exp_drp));
        end
      end else begin
        check("cool_entry_secs", int'(remaining_seconds), GAP);
        check("cool_valves", int'(sprinkler_bomb | dripper_valvule), 0);
      end
    end
  endtask

  task automatic cool_out();
    for (int i = 1; i <= GAP; i++) begin
      pulse_tick();
      check("cool_secs", int'(remaining_seconds), GAP - i);
    end
  endtask

  initial begin
    tbl[0] = '{l:1, m:0, h:0, valve:1, alarm:1, error:0};
    tbl[1] = '{l:1, m:1, h:0, valve:1, alarm:0, error:0};
    tbl[2] = '{l:1, m:1, h:1, valve:0, alarm:0, error:0};
    tbl[3] = '{l:1, m:1, h:0, valve:0, alarm:0, error:0};
    tbl[4] = '{l:0, m:0, h:0, valve:1, alarm:1, error:0};
    tbl[5] = '{l:1, m:0, h:1, valve:0, alarm:1, error:1};
    tbl[6] = '{l:1, m:1, h:0, valve:0, alarm:1, error:1};

    reset = 1'b1; tick_1hz = 1'b0;
    low_water_level = 1'b1; mid_water_level = 1'b1; high_water_level = 1'b0;
    air_humidity = 1'b0; low_temperature = 1'b0;
    earth_humidity = 4'b1111; zone_enable = 4'b0000;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_sprinkler", int'(sprinkler_bomb), 0);
    check("rst_dripper", int'(dripper_valvule), 0);
    check("rst_zone", int'(active_zone), 0);
    check("rst_secs", int'(remaining_seconds), 0);
    check("rst_supply", int'(water_supply_valvule), 0);
    check("rst_alarm", int'(alarm), 0);
    check("rst_error", int'(error), 0);

    // Tank level table: hysteresis of the inlet, alarm, and fault latching.
    for (int i = 0; i < 7; i++) begin
      low_water_level = tbl[i].l; mid_water_level = tbl[i].m; high_water_level = tbl[i].h;
      step();
      check($sformatf("lvl%0d_supply", i), int'(water_supply_valvule), int'(tbl[i].valve));
      check($sformatf("lvl%0d_alarm", i), int'(alarm), int'(tbl[i].alarm));
      check($sformatf("lvl%0d_error", i), int'(error), int'(tbl[i].error));
    end
    pulse_tick();
    check("fault_exit_error", int'(error), 0);
    check("fault_exit_secs", int'(remaining_seconds), GAP);
    cool_out();

    // Single dry zone, dry warm air: sprinkler run then cooldown.
    earth_humidity = 4'b1011; zone_enable = 4'b0100;
    wait_drive(4'b0100, 4'b0000, 2, SPR);
    run_out(SPR, 4'b0100, 4'b0000);
    cool_out();
    check("idle_valves", int'(sprinkler_bomb | dripper_valvule), 0);
    zone_enable = 4'b0000;

    // Two dry zones, humid air: dripper runs alternate round-robin.
    earth_humidity = 4'b1100; zone_enable = 4'b0011; air_humidity = 1'b1;
    wait_drive(4'b0000, 4'b0001, 0, DRP);
    run_out(DRP, 4'b0000, 4'b0001);
    cool_out();
    wait_drive(4'b0000, 4'b0010, 1, DRP);
    run_out(DRP, 4'b0000, 4'b0010);
    cool_out();
    wait_drive(4'b0000, 4'b0001, 0, DRP);

    // Soil turns wet mid-run: abort straight into cooldown.
    repeat (3) pulse_tick();
    check("abort_pre_secs", int'(remaining_seconds), DRP - 3);
    earth_humidity = 4'b1101;
    step();
    check("abort_dripper", int'(dripper_valvule), 0);
    check("abort_secs", int'(remaining_seconds), GAP);
    cool_out();

    // Sensor conflict mid-run.
    wait_drive(4'b0000, 4'b0010, 1, DRP);
    high_water_level = 1'b1; mid_water_level = 1'b0;
    step();
    check("conf_error", int'(error), 1);
    check("conf_alarm", int'(alarm), 1);
    check("conf_valves", int'(sprinkler_bomb | dripper_valvule), 0);
    check("conf_secs", int'(remaining_seconds), 0);
    high_water_level = 1'b0; mid_water_level = 1'b1;
    step();
    check("conf_hold_error", int'(error), 1);
    pulse_tick();
    check("conf_exit_error", int'(error), 0);
    check("conf_exit_alarm", int'(alarm), 0);
    check("conf_exit_secs", int'(remaining_seconds), GAP);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
